// File: rtl/lc3_cpu.sv
// Multicycle LC-3 core: FETCH/DECODE/EXEC plus up to two memory accesses per
// instruction over one shared request/ready port with registered request outputs.
module lc3_cpu #(
    parameter logic [15:0] RESET_PC  = 16'h3000,
    parameter logic [7:0]  HALT_VECT = 8'h25
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] pc,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_ADDR, MEM_DATA, HALT} state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    state_t      state, next_state;
    logic [15:0] ir, ea, op_a, op_b;
    logic [15:0] regs [8];
    logic [2:0]  nzp;

    logic [3:0]  opcode;
    logic [2:0]  dr, sr1;
    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] ea_calc, alu_out, want_addr, want_wdata;
    logic        done, halt_trap, illegal, mem_op;
    logic        want_re, want_we;
    logic        rf_we, cc_we, pc_we, ptr_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data, pc_data;

    assign opcode     = ir[15:12];
    assign dr         = ir[11:9];
    assign sr1        = ir[8:6];
    assign sext5      = {{11{ir[4]}}, ir[4:0]};
    assign sext6      = {{10{ir[5]}}, ir[5:0]};
    assign sext9      = {{7{ir[8]}}, ir[8:0]};
    assign sext11     = {{5{ir[10]}}, ir[10:0]};
    assign done       = (mem_re | mem_we) & mem_ready;
    assign halt_trap  = (opcode == OP_TRAP) && (ir[7:0] == HALT_VECT);
    assign illegal    = (opcode == OP_RTI) || (opcode == OP_RES);
    assign want_wdata = regs[dr];
    assign halted     = (state == HALT);

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])           return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                 return 3'b001;
    endfunction

    always_comb begin
        case (opcode)
            OP_LD, OP_ST, OP_LDR, OP_STR, OP_LDI, OP_STI: mem_op = 1'b1;
            OP_TRAP: mem_op = !halt_trap;
            default: mem_op = 1'b0;
        endcase
    end

    // PC here is already incremented, so PC-relative targets come out right.
    always_comb begin
        case (opcode)
            OP_LDR, OP_STR: ea_calc = regs[sr1] + sext6;
            OP_TRAP:        ea_calc = {8'h00, ir[7:0]};
            OP_JMP:         ea_calc = regs[sr1];
            OP_JSR:         ea_calc = ir[11] ? (pc + sext11) : regs[sr1];
            default:        ea_calc = pc + sext9;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ADD:  alu_out = op_a + op_b;
            OP_AND:  alu_out = op_a & op_b;
            default: alu_out = ~op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        want_re    = 1'b0;
        want_we    = 1'b0;
        want_addr  = pc;
        rf_we      = 1'b0;
        rf_addr    = dr;
        rf_data    = alu_out;
        cc_we      = 1'b0;
        pc_we      = 1'b0;
        pc_data    = ea;
        ptr_we     = 1'b0;
        case (state)
            FETCH: begin
                want_re = 1'b1;
                if (done) next_state = DECODE;
            end
            DECODE: begin
                if (illegal || halt_trap) next_state = HALT;
                else if (mem_op)          next_state = MEM_ADDR;
                else                      next_state = EXEC;
            end
            EXEC: begin
                next_state = FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_we = 1'b1;
                        cc_we = 1'b1;
                    end
                    OP_LEA: begin
                        rf_we   = 1'b1;
                        cc_we   = 1'b1;
                        rf_data = ea;
                    end
                    OP_BR:  pc_we = |(dr & nzp);
                    OP_JMP: pc_we = 1'b1;
                    // ea was latched in DECODE, so JSRR R7 jumps through the old R7.
                    OP_JSR: begin
                        pc_we   = 1'b1;
                        rf_we   = 1'b1;
                        rf_addr = 3'd7;
                        rf_data = pc;
                    end
                    default: ;
                endcase
            end
            MEM_ADDR: begin
                want_addr = ea;
                want_we   = (opcode == OP_ST) || (opcode == OP_STR);
                want_re   = !want_we;
                if (done) begin
                    next_state = FETCH;
                    case (opcode)
                        OP_LDI, OP_STI: begin
                            next_state = MEM_DATA;
                            ptr_we     = 1'b1;
                        end
                        OP_LD, OP_LDR: begin
                            rf_we   = 1'b1;
                            cc_we   = 1'b1;
                            rf_data = mem_rdata;
                        end
                        OP_TRAP: begin
                            rf_we   = 1'b1;
                            rf_addr = 3'd7;
                            rf_data = pc;
                            pc_we   = 1'b1;
                            pc_data = mem_rdata;
                        end
                        default: ;
                    endcase
                end
            end
            MEM_DATA: begin
                want_addr = ea;
                want_we   = (opcode == OP_STI);
                want_re   = !want_we;
                if (done) begin
                    next_state = FETCH;
                    if (opcode == OP_LDI) begin
                        rf_we   = 1'b1;
                        cc_we   = 1'b1;
                        rf_data = mem_rdata;
                    end
                end
            end
            HALT: ;
            default: next_state = FETCH;
        endcase
    end

    // A request is launched one cycle into an access state and then held
    // unchanged until the ready edge retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
        end else if (done) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
        end else if (!mem_re && !mem_we && (want_re || want_we)) begin
            mem_re    <= want_re;
            mem_we    <= want_we;
            mem_addr  <= want_addr;
            mem_wdata <= want_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            ir   <= 16'h0000;
            nzp  <= 3'b010;
            ea   <= 16'h0000;
            op_a <= 16'h0000;
            op_b <= 16'h0000;
            regs <= '{default: 16'h0000};
        end else begin
            if (state == FETCH && done) begin
                ir <= mem_rdata;
                pc <= pc + 16'd1;
            end
            if (state == DECODE) begin
                ea   <= ea_calc;
                op_a <= regs[sr1];
                op_b <= ir[5] ? sext5 : regs[ir[2:0]];
            end
            if (ptr_we) ea <= mem_rdata;
            if (rf_we)  regs[rf_addr] <= rf_data;
            if (cc_we)  nzp <= cc_of(rf_data);
            if (pc_we)  pc <= pc_data;
        end
    end
endmodule

// File: tb/tb_lc3_cpu.sv
// Directed bench for lc3_cpu: runs a short LC-3 program against a behavioural
// memory with programmable ready stalls, checking state at fixed program points.
module tb_lc3_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr, mem_wdata, pc;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_re, mem_we, halted;
    logic        mem_ready = 1'b0;

    logic [15:0] mem [0:65535];
    logic [15:0] log_addr [$];
    logic        log_we [$];
    logic [15:0] arm_addr = 16'h0000;
    int          arm_n = 0;
    int          stall_left = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    lc3_cpu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Ready/read data are set up on the falling edge for the next rising edge;
    // an armed address stalls its first request for arm_n cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready  = 1'b0;
            stall_left = 0;
        end else if (mem_re || mem_we) begin
            if (arm_n > 0 && mem_addr == arm_addr) begin
                stall_left = arm_n;
                arm_n      = 0;
            end
            if (stall_left > 0) begin
                mem_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_ready && (mem_re || mem_we)) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input int cycles);
        rst_n = rst_val;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input logic [15:0] a, input logic we, input string tag);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < 300) begin
            @(posedge clk);
            #1;
            hit = (we ? mem_we : mem_re) && (mem_addr == a);
            n++;
        end
        checkOutput({tag, "_seen"}, {15'd0, hit}, 16'd1);
    endtask

    task automatic waitHalt();
        int n = 0;
        while (!halted && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("halt_seen", {15'd0, halted}, 16'd1);
    endtask

    initial begin
        int cnt;
        int idx;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'h1262;  // ADD R1,R1,#2
        mem[16'h3001] = 16'h127F;  // ADD R1,R1,#-1
        mem[16'h3002] = 16'h241D;  // LD R2,[3020]
        mem[16'h3003] = 16'h0801;  // BRn +1
        mem[16'h3004] = 16'h1261;  // ADD R1,R1,#1 (must be skipped)
        mem[16'h3005] = 16'h0401;  // BRz +1 (not taken)
        mem[16'h3006] = 16'h261A;  // LD R3,[3021]
        mem[16'h3007] = 16'h74C0;  // STR R2,R3,#0
        mem[16'h3008] = 16'h0E07;  // BRnzp to 3010
        mem[16'h3010] = 16'h4804;  // JSR +4 -> 3015
        mem[16'h3011] = 16'hA810;  // LDI R4,[[3022]]
        mem[16'h3012] = 16'hF025;  // TRAP x25 (halt)
        mem[16'h3015] = 16'hC1C0;  // RET
        mem[16'h3020] = 16'h8000;
        mem[16'h3021] = 16'h4000;
        mem[16'h3022] = 16'h4100;
        mem[16'h4100] = 16'h1234;

        applyStimulus(1'b0, 2);
        checkOutput("rst_pc", pc, 16'h3000);
        checkOutput("rst_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst_mem_re", {15'd0, mem_re}, 16'd0);
        checkOutput("rst_mem_we", {15'd0, mem_we}, 16'd0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_nzp", {13'd0, dut.nzp}, 16'h0002);
        checkOutput("rst_r1", dut.regs[1], 16'h0000);

        arm_addr = 16'h3001;
        arm_n    = 3;
        applyStimulus(1'b1, 0);
        waitReq(16'h3000, 1'b0, "first_fetch");
        checkOutput("first_fetch_addr", mem_addr, 16'h3000);

        waitReq(16'h3001, 1'b0, "fetch_3001");
        checkOutput("add_imm2_r1", dut.regs[1], 16'h0002);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_re", {15'd0, mem_re}, 16'd1);
            checkOutput("stall_addr", mem_addr, 16'h3001);
            checkOutput("stall_pc", pc, 16'h3001);
        end
        arm_addr = 16'h4000;
        arm_n    = 2;

        waitReq(16'h3002, 1'b0, "fetch_3002");
        checkOutput("add_neg1_r1", dut.regs[1], 16'h0001);
        checkOutput("add_neg1_nzp", {13'd0, dut.nzp}, 16'h0001);

        waitReq(16'h3003, 1'b0, "fetch_3003");
        checkOutput("ld_r2", dut.regs[2], 16'h8000);
        checkOutput("ld_nzp", {13'd0, dut.nzp}, 16'h0004);

        waitReq(16'h3005, 1'b0, "brn_target");
        checkOutput("brn_pc", pc, 16'h3005);
        waitReq(16'h3006, 1'b0, "brz_fallthru");
        checkOutput("brz_nzp_kept", {13'd0, dut.nzp}, 16'h0004);

        waitReq(16'h4000, 1'b1, "str_write");
        checkOutput("str_wdata", mem_wdata, 16'h8000);
        checkOutput("str_no_re", {15'd0, mem_re}, 16'd0);
        checkOutput("str_r3", dut.regs[3], 16'h4000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("str_we_held", {15'd0, mem_we}, 16'd1);
            checkOutput("str_wdata_held", mem_wdata, 16'h8000);
        end
        @(posedge clk);
        #1;
        checkOutput("str_we_dropped", {15'd0, mem_we}, 16'd0);
        checkOutput("str_mem", mem[16'h4000], 16'h8000);

        waitReq(16'h3010, 1'b0, "fetch_jsr");
        waitReq(16'h3015, 1'b0, "jsr_target");
        checkOutput("jsr_r7", dut.regs[7], 16'h3011);
        waitReq(16'h3011, 1'b0, "ret_target");
        checkOutput("ret_pc", pc, 16'h3011);

        waitHalt();
        checkOutput("ldi_r4", dut.regs[4], 16'h1234);
        checkOutput("ldi_nzp", {13'd0, dut.nzp}, 16'h0001);
        checkOutput("halt_pc", pc, 16'h3013);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("halt_pc_frozen", pc, 16'h3013);
        checkOutput("halt_held", {15'd0, halted}, 16'd1);
        checkOutput("halt_no_re", {15'd0, mem_re}, 16'd0);
        checkOutput("halt_r1_final", dut.regs[1], 16'h0001);

        cnt = 0;
        foreach (log_we[i]) if (log_we[i]) cnt++;
        checkOutput("write_count", cnt[15:0], 16'd1);
        cnt = 0;
        foreach (log_addr[i]) if (log_addr[i] == 16'h3004 || log_addr[i] == 16'h0025) cnt++;
        checkOutput("skipped_accesses", cnt[15:0], 16'd0);
        idx = -1;
        foreach (log_addr[i]) if (idx < 0 && log_addr[i] == 16'h3022 && !log_we[i]) idx = i;
        checkOutput("ldi_ptr_read", {15'd0, idx >= 0}, 16'd1);
        if (idx >= 0 && idx + 1 < log_addr.size())
            checkOutput("ldi_second_read", log_addr[idx+1], 16'h4100);
        else
            checkOutput("ldi_second_read", 16'hFFFF, 16'h4100);

        applyStimulus(1'b0, 2);
        checkOutput("rst2_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst2_pc", pc, 16'h3000);
        checkOutput("rst2_r1", dut.regs[1], 16'h0000);
        arm_addr = 16'h3000;
        arm_n    = 5;
        applyStimulus(1'b1, 0);
        waitReq(16'h3000, 1'b0, "stall2_fetch");
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 0);
        #1;
        checkOutput("midstall_re", {15'd0, mem_re}, 16'd0);
        checkOutput("midstall_addr", mem_addr, 16'h0000);
        checkOutput("midstall_pc", pc, 16'h3000);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 0);
        waitReq(16'h3000, 1'b0, "restart_fetch");
        waitReq(16'h3001, 1'b0, "restart_3001");
        checkOutput("restart_r1", dut.regs[1], 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
